// File: rtl/stepper_pulse_generator.sv
// Single-axis step/direction/enable pulse generator driven by signed relative-move commands.
// Every step issued is visible on the pins, so downstream position counters track it exactly.
module stepper_pulse_generator #(
    parameter int PERIOD_W  = 16,
    parameter int PULSE_W   = 50,
    parameter int DIR_SETUP = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    input  logic                hold_enable,
    output logic                stepper_step,
    output logic                stepper_direction,
    output logic                stepper_enable,
    output logic                busy,
    output logic                done,
    output logic [31:0]         steps_remaining
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_W);
    localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(DIR_SETUP - 1);
    localparam logic [PERIOD_W-1:0] HIGH_LAST  = PERIOD_W'(PULSE_W - 1);
    localparam logic [PERIOD_W-1:0] LOW_TRIM   = PERIOD_W'(PULSE_W + 1);
    localparam logic [PERIOD_W-1:0] CNT_ONE    = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] CNT_ZERO   = PERIOD_W'(0);

    // Absolute value of the step count; 0x8000_0000 maps to 2^31 as an unsigned number.
    function automatic logic [31:0] step_magnitude(input logic [31:0] steps);
        logic [31:0] mag;
        if (steps[31]) begin
            mag = ~steps + 32'd1;
        end else begin
            mag = steps;
        end
        return mag;
    endfunction

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] period);
        logic [PERIOD_W-1:0] eff;
        if (period < MIN_PERIOD) begin
            eff = MIN_PERIOD;
        end else begin
            eff = period;
        end
        return eff;
    endfunction

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] low_last_q, low_last_d;
    logic [31:0]         rem_q, rem_d;
    logic                dir_q, dir_d;
    logic                step_q, step_d;
    logic                enable_q, enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                abort_pend_q, abort_pend_d;
    logic [31:0]         mag_s;

    assign mag_s = step_magnitude(cmd_steps);

    // Next-state and next-output computation for the move sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        low_last_d   = low_last_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        step_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ready_d      = ready_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (cmd_valid && ready_q) begin
                    dir_d        = cmd_steps[31];
                    rem_d        = mag_s;
                    low_last_d   = clamp_period(cmd_period) - LOW_TRIM;
                    abort_pend_d = 1'b0;
                    ready_d      = 1'b0;
                    if (mag_s == 32'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LAST;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HIGH;
                    step_d  = 1'b1;
                    rem_d   = rem_q - 32'd1;
                    cnt_d   = HIGH_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HIGH: begin
                abort_pend_d = abort_pend_q | abort;
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_LOW;
                    cnt_d   = low_last_q;
                end else begin
                    step_d = 1'b1;
                    cnt_d  = cnt_q - CNT_ONE;
                end
            end
            ST_LOW: begin
                abort_pend_d = abort_pend_q | abort;
                // An abort on the final LOW clock still ends the move after this pulse.
                if (cnt_q == CNT_ZERO) begin
                    if ((rem_q != 32'd0) && !(abort_pend_q || abort)) begin
                        state_d = ST_HIGH;
                        step_d  = 1'b1;
                        rem_d   = rem_q - 32'd1;
                        cnt_d   = HIGH_LAST;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
        enable_d = ~(busy_d | hold_enable);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            low_last_q   <= CNT_ZERO;
            rem_q        <= 32'd0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            enable_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            low_last_q   <= low_last_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign cmd_ready         = ready_q;
    assign stepper_step      = step_q;
    assign stepper_direction = dir_q;
    assign stepper_enable    = enable_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign steps_remaining   = rem_q;

endmodule

// File: tb/tb_stepper_pulse_generator.sv
// Bench for stepper_pulse_generator: closed-form timeline model checked every cycle,
// plus directed moves with hand-computed pulse times, done times and position counts.
module tb_stepper_pulse_generator;
    localparam int PW   = 2;
    localparam int DS   = 4;
    localparam int PERW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [31:0]     cmd_steps;
    logic [PERW-1:0] cmd_period;
    logic            abort;
    logic            hold_enable;
    logic            stepper_step;
    logic            stepper_direction;
    logic            stepper_enable;
    logic            busy;
    logic            done;
    logic [31:0]     steps_remaining;

    always #5 clk = ~clk;

    stepper_pulse_generator #(.PERIOD_W(PERW), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .hold_enable(hold_enable), .stepper_step(stepper_step),
        .stepper_direction(stepper_direction), .stepper_enable(stepper_enable),
        .busy(busy), .done(done), .steps_remaining(steps_remaining)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: a move is a timeline measured in edges k after the acceptance edge.
    longint cyc = 0;
    longint m_t0 = 0, m_mag = 0, m_eff = 0, m_n = 0, m_done_k = 0, m_acc_cyc = -1;
    longint last_rem = 0;
    bit     m_active = 0, m_neg = 0, m_valid = 0, last_dir = 0;
    logic   e_step, e_dir, e_en, e_busy, e_done, e_ready;
    logic [31:0] e_rem;

    task automatic model_edge();
        longint k, r;
        cyc++;
        if (!rst_n) begin
            m_valid = 1; m_active = 0; last_rem = 0; last_dir = 0;
            e_step = 0; e_dir = 0; e_en = 1; e_busy = 0; e_done = 0; e_ready = 1; e_rem = 0;
            return;
        end
        if (!m_valid) return;
        if (!m_active) begin
            if (e_ready && cmd_valid) begin
                m_active  = 1;
                m_t0      = cyc;
                m_acc_cyc = cyc;
                m_neg     = cmd_steps[31];
                m_mag     = cmd_steps[31] ? -longint'($signed(cmd_steps)) : longint'(cmd_steps);
                m_eff     = (int'(cmd_period) < 2 * PW) ? 2 * PW : longint'(cmd_period);
                m_n       = m_mag;
                m_done_k  = (m_mag == 0) ? 0 : DS + m_n * m_eff;
            end
        end else begin
            k = cyc - m_t0;
            if (abort && m_mag > 0 && k >= 1 && k <= m_done_k) begin
                if (k <= DS) begin
                    m_n = 0;
                    m_done_k = k;
                end else begin
                    m_n = (k - DS - 1) / m_eff + 1;
                    m_done_k = DS + m_n * m_eff;
                end
            end
        end
        k = cyc - m_t0;
        if (m_active && k > m_done_k) begin
            m_active = 0;
            last_rem = m_mag - m_n;
            last_dir = m_neg;
        end
        if (m_active) begin
            r = (k >= DS) ? (k - DS) / m_eff + 1 : 0;
            if (r > m_n) r = m_n;
            e_busy  = (k < m_done_k);
            e_step  = (k >= DS) && (((k - DS) % m_eff) < PW) && (((k - DS) / m_eff) < m_n);
            e_rem   = 32'(m_mag - r);
            e_dir   = m_neg;
            e_done  = (k == m_done_k);
            e_ready = 0;
        end else begin
            e_busy = 0; e_step = 0; e_done = 0; e_ready = 1;
            e_rem  = 32'(last_rem);
            e_dir  = last_dir;
        end
        e_en = !(e_busy || hold_enable);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // Compare and pin-level monitor (position counter, rise and done offsets).
    int  pos = 0;
    int  done_off = -1;
    int  rises[$];
    logic prev_step = 1'b0;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("step", {31'd0, stepper_step}, {31'd0, e_step});
            check("dir", {31'd0, stepper_direction}, {31'd0, e_dir});
            check("enable", {31'd0, stepper_enable}, {31'd0, e_en});
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("done", {31'd0, done}, {31'd0, e_done});
            check("ready", {31'd0, cmd_ready}, {31'd0, e_ready});
            check("remaining", steps_remaining, e_rem);
            if (stepper_step === 1'b1 && prev_step === 1'b0) begin
                rises.push_back(int'(cyc - m_t0));
                pos += (stepper_direction === 1'b1) ? -1 : 1;
            end
            prev_step = stepper_step;
            if (done === 1'b1) done_off = int'(cyc - m_t0);
        end
    end

    task automatic send(input logic [31:0] s, input logic [PERW-1:0] p);
        int i;
        rises.delete();
        pos = 0;
        done_off = -1;
        cmd_steps = s; cmd_period = p; cmd_valid = 1'b1;
        for (i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_acc_cyc == cyc) break;
        end
        check("accept timeout", {31'd0, (m_acc_cyc == cyc)}, 32'd1);
        cmd_valid = 1'b0;
        cmd_steps = 32'h0000_1234;
        cmd_period = 16'd3;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (cmd_ready === 1'b1 && busy === 1'b0) break;
            @(posedge clk); #1;
        end
        check("idle timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic check_test(input string name, input int exp_done, input int exp_pos,
                              input int nr, input int r0, input int r1, input int r2);
        int exp_r[3];
        exp_r[0] = r0; exp_r[1] = r1; exp_r[2] = r2;
        check({name, " model done_k"}, 32'(m_done_k), 32'(exp_done));
        check({name, " done offset"}, 32'(done_off), 32'(exp_done));
        check({name, " position"}, 32'(pos), 32'(exp_pos));
        check({name, " pulse count"}, 32'(rises.size()), 32'(nr));
        for (int i = 0; i < nr && i < rises.size(); i++)
            check({name, " rise time"}, 32'(rises[i]), 32'(exp_r[i]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_steps = 32'd0; cmd_period = 16'd0;
        abort = 1'b0; hold_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset ready", {31'd0, cmd_ready}, 32'd1);
        check("reset enable", {31'd0, stepper_enable}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        send(32'd3, 16'd10);
        wait_idle(100);
        check_test("t1 +3/10", 34, 3, 3, 4, 14, 24);

        send(-32'sd2, 16'd6);
        wait_idle(100);
        check_test("t2 -2/6", 16, -2, 2, 4, 10, 0);

        send(32'd0, 16'd10);
        wait_idle(20);
        check_test("t3 zero", 0, 0, 0, 0, 0, 0);

        send(32'd2, 16'd1);
        wait_idle(100);
        check_test("t4 clamp", 12, 2, 2, 4, 8, 0);

        send(32'd5, 16'd10);
        repeat (14) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle(100);
        check_test("t5 abort high", 24, 2, 2, 4, 14, 0);
        check("t5 remaining", steps_remaining, 32'd3);

        send(32'd2, 16'd10);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle(20);
        check_test("t6 abort setup", 2, 0, 0, 0, 0, 0);
        check("t6 remaining", steps_remaining, 32'd2);

        send(32'h8000_0000, 16'd4);
        check("t7 magnitude", steps_remaining, 32'h8000_0000);
        check("t7 direction", {31'd0, stepper_direction}, 32'd1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle(20);
        check_test("t7 min int", 2, 0, 0, 0, 0, 0);

        hold_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t8 hold idle enable", {31'd0, stepper_enable}, 32'd0);
        send(32'd1, 16'd4);
        wait_idle(40);
        check_test("t8 hold move", 8, 1, 1, 4, 0, 0);
        check("t8 hold after", {31'd0, stepper_enable}, 32'd0);
        hold_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(32'd3, 16'd10);
        repeat (4) @(posedge clk);
        #1;
        check("t9 step before reset", {31'd0, stepper_step}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t9 step after reset", {31'd0, stepper_step}, 32'd0);
        check("t9 enable after reset", {31'd0, stepper_enable}, 32'd1);
        check("t9 busy after reset", {31'd0, busy}, 32'd0);
        check("t9 remaining after reset", steps_remaining, 32'd0);
        send(32'd1, 16'd4);
        wait_idle(40);
        check_test("t9 after reset", 8, 1, 1, 4, 0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
